// File: rtl/image_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous image ROM between two pixel requesters.
// Returns tagged RGB responses three edges after acceptance; out-of-image x reads return DEFAULT_RGB.
module image_rom_arbiter #(
  parameter int          IMG_W       = 48,
  parameter logic [11:0] DEFAULT_RGB = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [11:0] req0_addr,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [11:0] req1_addr,
  output logic        req1_ready,
  output logic [11:0] rom_addr,
  input  logic [11:0] rom_rgb,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [11:0] rsp_rgb
);

  // x lives in the low six address bits; y is always in range.
  function automatic logic out_of_image(input logic [11:0] addr);
    return int'(addr[5:0]) >= IMG_W;
  endfunction

  logic        last_r;
  logic [11:0] rom_addr_r;
  logic        s1_valid_r, s1_id_r, s1_oor_r;
  logic        s2_valid_r, s2_id_r, s2_oor_r;
  logic        rsp_valid_r, rsp_id_r;
  logic [11:0] rsp_rgb_r;

  logic        gnt0_s, gnt1_s, accept_s, gnt_id_s, gnt_oor_s;
  logic [11:0] gnt_addr_s;

  // Grant selection: under contention the requester that did not win last time goes.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (rst) begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end else if (req0_valid && req1_valid) begin
      if (last_r) begin
        gnt0_s = 1'b1;
      end else begin
        gnt1_s = 1'b1;
      end
    end else begin
      gnt0_s = req0_valid;
      gnt1_s = req1_valid;
    end
    accept_s   = gnt0_s | gnt1_s;
    gnt_id_s   = gnt1_s;
    gnt_addr_s = gnt1_s ? req1_addr : req0_addr;
    gnt_oor_s  = out_of_image(gnt_addr_s);
  end

  // Arbitration pointer, ROM address and the three-stage response pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r      <= 1'b1;
      rom_addr_r  <= 12'h000;
      s1_valid_r  <= 1'b0;
      s1_id_r     <= 1'b0;
      s1_oor_r    <= 1'b0;
      s2_valid_r  <= 1'b0;
      s2_id_r     <= 1'b0;
      s2_oor_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_id_r    <= 1'b0;
      rsp_rgb_r   <= 12'h000;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        last_r   <= gnt_id_s;
        s1_id_r  <= gnt_id_s;
        s1_oor_r <= gnt_oor_s;
        // Out-of-image requests leave the ROM address alone to keep the index in range.
        if (!gnt_oor_s) begin
          rom_addr_r <= gnt_addr_s;
        end
      end
      s2_valid_r  <= s1_valid_r;
      s2_id_r     <= s1_id_r;
      s2_oor_r    <= s1_oor_r;
      rsp_valid_r <= s2_valid_r;
      if (s2_valid_r) begin
        rsp_id_r  <= s2_id_r;
        rsp_rgb_r <= s2_oor_r ? DEFAULT_RGB : rom_rgb;
      end
    end
  end

  assign req0_ready = gnt0_s;
  assign req1_ready = gnt1_s;
  assign rom_addr   = rom_addr_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_rgb    = rsp_rgb_r;

endmodule

// File: tb/tb_image_rom_arbiter.sv
// Scoreboard bench for image_rom_arbiter: directed scenarios followed by randomized traffic,
// with a negedge monitor comparing grants, ROM address and responses against a reference model.
module tb_image_rom_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [11:0] req0_addr = 12'h000, req1_addr = 12'h000;
  logic        req0_ready, req1_ready;
  logic [11:0] rom_addr, rom_rgb;
  logic        rsp_valid, rsp_id;
  logic [11:0] rsp_rgb;

  image_rom_arbiter #(.IMG_W(48), .DEFAULT_RGB(12'h000)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rom_addr(rom_addr), .rom_rgb(rom_rgb),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rgb(rsp_rgb)
  );

  always #5 clk = ~clk;

  // Image ROM model: synchronous, one-cycle read latency.
  logic [11:0] rom [4096];
  always @(posedge clk) rom_rgb <= rom[rom_addr];

  typedef struct {
    logic        id;
    logic [11:0] rgb;
    int          due;
  } exp_t;
  exp_t q[$];

  int          checks = 0, failures = 0, cyc = 0;
  logic        rst_q = 1'b1;
  bit          mon_en = 1'b0;
  logic        tb_last = 1'b1;
  logic [11:0] exp_addr = 12'h000;
  bit          acc0 = 1'b0, acc1 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  // Monitor and reference model, evaluated mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      logic        g0, g1, exp_v, oor;
      logic [11:0] a;
      exp_t        e;
      exp_v = (q.size() > 0) && (q[0].due == cyc);
      chk("rsp_valid", rsp_valid, exp_v);
      if (exp_v) begin
        e = q.pop_front();
        if (rsp_valid) begin
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_rgb", rsp_rgb, e.rgb);
        end
      end
      if (rst_q) begin
        chk("reset_rsp_id", rsp_id, 1'b0);
        chk("reset_rsp_rgb", rsp_rgb, 12'h000);
      end
      chk("rom_addr", rom_addr, exp_addr);
      g0 = 1'b0;
      g1 = 1'b0;
      if (!rst) begin
        if (req0_valid && req1_valid) begin
          g0 = tb_last;
          g1 = !tb_last;
        end else begin
          g0 = req0_valid;
          g1 = req1_valid;
        end
      end
      chk("req0_ready", req0_ready, g0);
      chk("req1_ready", req1_ready, g1);
      acc0 = g0;
      acc1 = g1;
      if (rst) begin
        q.delete();
        tb_last  = 1'b1;
        exp_addr = 12'h000;
      end else if (g0 || g1) begin
        a   = g1 ? req1_addr : req0_addr;
        oor = (a[5:0] >= 6'd48);
        q.push_back('{g1, oor ? 12'h000 : rom[a], cyc + 3});
        tb_last = g1;
        if (!oor) exp_addr = a;
      end
    end
  end

  function automatic logic [11:0] rand_addr();
    logic [5:0] y;
    y = 6'($urandom_range(0, 63));
    case ($urandom_range(0, 7))
      0:       return {y, 6'($urandom_range(48, 63))};
      1:       return 12'hFEF;
      2:       return 12'h000;
      3:       return {y, 6'd47};
      default: return {y, 6'($urandom_range(0, 47))};
    endcase
  endfunction

  task automatic drive(input logic v0, input logic [11:0] a0, input logic v1, input logic [11:0] a1);
    @(posedge clk);
    #1;
    req0_valid = v0; req0_addr = a0;
    req1_valid = v1; req1_addr = a1;
    @(negedge clk);
  endtask

  // Requesters hold valid/addr until accepted, then pick a new random request.
  task automatic run_rand(input int n, input int pv0, input int pv1);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (!req0_valid || acc0) begin
        req0_valid = ($urandom_range(0, 99) < pv0);
        req0_addr  = rand_addr();
      end
      if (!req1_valid || acc1) begin
        req1_valid = ($urandom_range(0, 99) < pv1);
        req1_addr  = rand_addr();
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 12'($urandom_range(1, 4095));
    rom[12'h085] = 12'h3C7;
    rom[12'hFEF] = 12'hABC;
    rom[12'h000] = 12'h5A5;
    rom[12'h032] = 12'hF0F;

    repeat (3) @(posedge clk);
    #1 mon_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // Single request from requester 0.
    drive(1'b1, {6'd2, 6'd5}, 1'b0, 12'h000);
    chk("t1_ready0", req0_ready, 1'b1);
    drive(1'b0, 12'h000, 1'b0, 12'h000);
    chk("t1_rom_addr", rom_addr, 12'h085);

    // Out-of-image request from requester 1 leaves rom_addr alone.
    drive(1'b0, 12'h000, 1'b1, {6'd0, 6'd50});
    chk("oor_ready1", req1_ready, 1'b1);
    drive(1'b0, 12'h000, 1'b0, 12'h000);
    chk("oor_rom_addr", rom_addr, 12'h085);

    // Continuous contention alternates starting with requester 0.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, {6'(i), 6'd10}, 1'b1, {6'(i + 20), 6'd30});
      chk("alt_ready0", req0_ready, (i % 2) == 0);
    end

    // Three accepts, then reset drops everything in flight.
    for (int i = 0; i < 3; i++) drive(1'b1, {6'd7, 6'(i)}, 1'b1, {6'd9, 6'(i + 3)});
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_ready0", req0_ready, 1'b1);
    chk("post_reset_ready1", req1_ready, 1'b0);

    // Requester 1 alone four times, then contention goes to requester 0.
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 12'h000, 1'b1, {6'(i + 40), 6'(i + 1)});
      chk("solo_ready1", req1_ready, 1'b1);
    end
    drive(1'b1, {6'd11, 6'd12}, 1'b1, {6'd13, 6'd14});
    chk("contend_ready0", req0_ready, 1'b1);

    // Boundary in-image addresses.
    drive(1'b1, 12'hFEF, 1'b0, 12'h000);
    drive(1'b1, 12'h000, 1'b0, 12'h000);
    chk("bnd_rom_addr_fef", rom_addr, 12'hFEF);
    drive(1'b0, 12'h000, 1'b0, 12'h000);
    chk("bnd_rom_addr_000", rom_addr, 12'h000);

    run_rand(300, 70, 70);
    run_rand(200, 100, 100);
    run_rand(200, 30, 90);

    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/image_rom_arbiter.md
Name: image_rom_arbiter

Overview:
- Shares one 48x64 image ROM between two pixel-fetch requesters, e.g. two card-drawing pipelines.
- ROM properties: synchronous, single read port, 1-cycle read latency, address {y[5:0],x[5:0]}, 12-bit RGB out.
- Arbitrates round-robin with valid/ready, drives the ROM address, and returns tagged RGB responses.
- Out-of-image reads (x >= 48) are substituted with a default colour.

Parameters:
- IMG_W, 48, image width in pixels; x >= IMG_W is out-of-image.
- DEFAULT_RGB, 12'h000, colour returned for out-of-image requests.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req0_valid  in  1  requester 0 has a read pending.
- req0_addr  in  12  requester 0 address {y[5:0],x[5:0]}.
- req0_ready  out  1  requester 0 granted this cycle.
- req1_valid  in  1  requester 1 has a read pending.
- req1_addr  in  12  requester 1 address.
- req1_ready  out  1  requester 1 granted this cycle.
- rom_addr  out  12  address to image ROM; registered.
- rom_rgb  in  12  ROM data, valid one edge after rom_addr.
- rsp_valid  out  1  response valid; one-cycle pulse per accepted request.
- rsp_id  out  1  requester index of the response.
- rsp_rgb  out  12  pixel colour.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, port rst.
- Reset values:
  - rom_addr=0, rsp_valid=0, rsp_id=0, rsp_rgb=0.
  - Pipeline valid flags cleared.
  - Round-robin pointer last=1, so requester 0 wins the first contention.
- Arbitration is combinational from valids and last:
  - Only req0 valid -> req0_ready=1.
  - Only req1 valid -> req1_ready=1.
  - Both valid -> grant the index != last.
  - At most one ready high per cycle.
  - Readies are 0 while rst=1.
- A transfer occurs on a clk edge where valid && ready. On transfer, last <= granted index. No transfer -> last unchanged.
- Requesters hold valid and addr stable until ready. The block never requires ready before valid.
- Pipeline, accept at edge E0:
  - E0: rom_addr <= granted addr (unless out-of-image), s1_valid<=1, s1_id, s1_oor <= (x >= IMG_W).
  - E1: ROM registers rom_rgb; s2_valid/s2_id/s2_oor <= s1.
  - E2: rsp_valid<=1, rsp_id<=s2_id, rsp_rgb <= s2_oor ? DEFAULT_RGB : rom_rgb.
- Latency: rsp_valid is high in the cycle following E2, i.e. 3 edges after acceptance.
- Throughput is 1 request per cycle sustained. Responses return in acceptance order.
- No idle transfer -> rom_addr holds its previous value; s1_valid <= 0.
- Out-of-image request: rom_addr is not updated, to avoid an out-of-range ROM index. Response is still produced with identical latency.
- y is 6 bits and always in range (0..63). Only x is range-checked.
- No response backpressure: consumers must accept rsp_valid the cycle it is high.
- Reset mid-operation: all in-flight requests are dropped; no rsp_valid is emitted for them after reset.
- A request whose valid is high during rst is not accepted. It is arbitrated normally from the first cycle after rst deasserts.
- Simultaneous valid both requesters every cycle -> strict alternation 0,1,0,1,...

Test Plan:
- Reset, then req0_valid with addr {6'd2,6'd5} for 1 cycle -> req0_ready=1 that cycle; rom_addr=12'h085 next cycle; rsp_valid=1, rsp_id=0, rsp_rgb=rom[12'h085] 3 edges after accept.
- Both valid held continuously with distinct addresses -> grants alternate 0,1,0,1 starting with 0; responses back-to-back every cycle, ids alternating, each matching its address.
- req1 addr {6'd0,6'd50} (x=50 >= 48) -> rsp_rgb=12'h000 (DEFAULT_RGB); rom_addr unchanged from prior value.
- Accept 3 requests on consecutive cycles, assert rst on the cycle after the third -> no rsp_valid after rst; all outputs at reset values; first post-reset contention is granted to req0.
- Only req1 valid for 4 cycles, then both -> req1 granted 4 times, then req0 wins the contention (last=1).
- Boundary addresses x=47,y=63 (12'hFEF) and x=0,y=0 -> ROM data returned unmodified, not replaced by the default.
